// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue path: instruction layout,
// opcodes, issue-queue FSM states and field-extraction helpers.
package alu_pkg;

  localparam int INSTR_W   = 18;
  localparam int DATA_W    = 8;
  localparam int OP_W      = 2;
  localparam int OP_LSB    = 16;
  localparam int A_LSB     = 8;
  localparam int B_LSB     = 0;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } iq_state_e;

  function automatic logic [OP_W-1:0] instr_op(input logic [INSTR_W-1:0] instr);
    return instr[OP_LSB +: OP_W];
  endfunction

  function automatic logic [DATA_W-1:0] instr_a(input logic [INSTR_W-1:0] instr);
    return instr[A_LSB +: DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] instr_b(input logic [INSTR_W-1:0] instr);
    return instr[B_LSB +: DATA_W];
  endfunction

endpackage

// File: rtl/alu_instr_fifo.sv
// Instruction FIFO: DEPTH entries, head visible combinationally, pointers wrap mod DEPTH.
// Push is ignored when full, pop ignored when empty; push+pop together keeps the count.
module alu_instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != FULL);
  assign do_pop  = pop_i && (count_q != '0);

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/alu_issue_queue.sv
// Issue queue feeding an external combinational ALU; head issues one edge after push,
// one per cycle while res_ready=1. A stalled result holds all res_* and blocks issue.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [INSTR_W-1:0]     in_instr,
  output logic                   in_ready,
  output logic [INSTR_W-1:0]     alu_instr,
  input  logic [DATA_W-1:0]      alu_x,
  input  logic [DATA_W-1:0]      alu_y,
  input  logic                   alu_ovf,
  input  logic                   alu_carry,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [OP_W-1:0]        res_op,
  output logic [DATA_W-1:0]      res_x,
  output logic [DATA_W-1:0]      res_y,
  output logic                   res_ovf,
  output logic                   res_carry,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  iq_state_e          state_q;
  logic               res_valid_q;
  logic [OP_W-1:0]    res_op_q;
  logic [DATA_W-1:0]  res_x_q, res_y_q;
  logic               res_ovf_q, res_carry_q;

  logic [INSTR_W-1:0] head;
  logic               not_empty, push, issue;

  assign not_empty = (count != '0);
  assign in_ready  = (count < FULL);
  assign push      = in_valid && in_ready;
  assign issue     = not_empty && (!res_valid_q || res_ready);
  assign alu_instr = not_empty ? head : '0;

  alu_instr_fifo #(
    .DEPTH (DEPTH),
    .W     (INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (issue),
    .wdata_i (in_instr),
    .rdata_o (head),
    .count_o (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      res_valid_q <= 1'b0;
      res_op_q    <= '0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      res_ovf_q   <= 1'b0;
      res_carry_q <= 1'b0;
    end else begin
      if (issue) begin
        res_op_q    <= instr_op(alu_instr);
        res_x_q     <= alu_x;
        res_y_q     <= alu_y;
        res_ovf_q   <= alu_ovf;
        res_carry_q <= alu_carry;
      end
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            state_q     <= ST_RUN;
            res_valid_q <= 1'b1;
          end
        end
        ST_RUN, ST_STALL: begin
          // Accepted with nothing to replace it drops straight to IDLE so res_valid clears.
          if (!res_ready) begin
            state_q <= ST_STALL;
          end else if (issue) begin
            state_q <= ST_RUN;
          end else begin
            state_q     <= ST_IDLE;
            res_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_op    = res_op_q;
  assign res_x     = res_x_q;
  assign res_y     = res_y_q;
  assign res_ovf   = res_ovf_q;
  assign res_carry = res_carry_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: behavioural ALU plus a queue-based reference model.
module tb_alu_issue_queue;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [17:0] in_instr = '0;
  logic        in_ready;
  logic [17:0] alu_instr;
  logic [7:0]  alu_x, alu_y;
  logic        alu_ovf, alu_carry;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [1:0]  res_op;
  logic [7:0]  res_x, res_y;
  logic        res_ovf, res_carry;
  logic [2:0]  count;
  logic [19:0] res_all;

  int n_chk = 0;
  int n_pass = 0;

  logic [17:0] mq[$];
  logic        m_vld = 1'b0;
  logic [19:0] m_res = '0;

  always #5 clk = ~clk;

  alu_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .alu_instr(alu_instr), .alu_x(alu_x), .alu_y(alu_y), .alu_ovf(alu_ovf), .alu_carry(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready), .res_op(res_op), .res_x(res_x), .res_y(res_y),
    .res_ovf(res_ovf), .res_carry(res_carry), .count(count)
  );

  assign res_all = {res_op, res_x, res_y, res_ovf, res_carry};

  // Returns {x, y, ovf, carry} for one instruction using plain arithmetic.
  function automatic logic [17:0] alu_fn(input logic [17:0] i);
    logic [7:0] a, b, y, x;
    logic [8:0] s;
    logic [15:0] p;
    logic ovf, c;
    a = i[15:8]; b = i[7:0]; x = 8'h00; y = 8'h00; ovf = 1'b0; c = 1'b0;
    case (i[17:16])
      2'b00: begin s = {1'b0, a} + {1'b0, b}; y = s[7:0]; c = s[8];
                   ovf = (a[7] == b[7]) && (y[7] != a[7]); end
      2'b01: begin p = a * b; x = p[15:8]; y = p[7:0]; end
      2'b10: y = a & b;
      default: y = a ^ b;
    endcase
    return {x, y, ovf, c};
  endfunction

  function automatic logic [19:0] expect_res(input logic [17:0] i);
    return {i[17:16], alu_fn(i)};
  endfunction

  always_comb {alu_x, alu_y, alu_ovf, alu_carry} = alu_fn(alu_instr);

  task automatic tick(input logic v, input logic [17:0] ins, input logic rr);
    logic do_push, do_issue;
    logic [17:0] h;
    in_valid = v; in_instr = ins; res_ready = rr;
    do_push  = v && (mq.size() < DEPTH);
    do_issue = (mq.size() > 0) && (!m_vld || rr);
    if (do_issue) begin
      h = mq.pop_front();
      m_res = expect_res(h);
      m_vld = 1'b1;
    end else if (m_vld && rr) begin
      m_vld = 1'b0;
    end
    if (do_push) mq.push_back(ins);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete(); m_vld = 1'b0; m_res = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_chk++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid got %b want 0", res_valid); else n_pass++;
    n_chk++; if (res_all !== 20'h0) $display("FAIL reset_res_fields got %h want 0", res_all); else n_pass++;
    n_chk++; if (alu_instr !== 18'h0) $display("FAIL reset_alu_instr got %h want 0", alu_instr); else n_pass++;
  endtask

  task automatic test_add();
    tick(1'b1, 18'h00503, 1'b1);
    n_chk++; if (count !== 3'd1) $display("FAIL add_count_after_push got %0d want 1", count); else n_pass++;
    n_chk++; if (res_valid !== 1'b0) $display("FAIL add_no_bypass got %b want 0", res_valid); else n_pass++;
    n_chk++; if (alu_instr !== 18'h00503) $display("FAIL add_alu_instr got %h want 00503", alu_instr); else n_pass++;
    tick(1'b0, 18'h0, 1'b1);
    n_chk++; if (res_valid !== 1'b1) $display("FAIL add_res_valid got %b want 1", res_valid); else n_pass++;
    n_chk++; if (res_all !== {2'b00, 8'h00, 8'h08, 1'b0, 1'b0})
      $display("FAIL add_result got %h want %h", res_all, {2'b00, 8'h00, 8'h08, 1'b0, 1'b0}); else n_pass++;
    tick(1'b0, 18'h0, 1'b1);
    n_chk++; if (res_valid !== 1'b0) $display("FAIL add_res_clear got %b want 0", res_valid); else n_pass++;
  endtask

  task automatic test_overflow();
    tick(1'b1, {2'b00, 8'h7f, 8'h01}, 1'b1);
    tick(1'b1, {2'b00, 8'hff, 8'h01}, 1'b1);
    n_chk++; if ({res_valid, res_y, res_ovf, res_carry} !== {1'b1, 8'h80, 1'b1, 1'b0})
      $display("FAIL ovf_signed got v%b y%h o%b c%b want v1 y80 o1 c0", res_valid, res_y, res_ovf, res_carry); else n_pass++;
    tick(1'b0, 18'h0, 1'b1);
    n_chk++; if ({res_valid, res_y, res_ovf, res_carry} !== {1'b1, 8'h00, 1'b0, 1'b1})
      $display("FAIL ovf_carry got v%b y%h o%b c%b want v1 y00 o0 c1", res_valid, res_y, res_ovf, res_carry); else n_pass++;
    tick(1'b0, 18'h0, 1'b1);
  endtask

  task automatic test_mul();
    tick(1'b1, 18'h11010, 1'b1);
    tick(1'b0, 18'h0, 1'b1);
    n_chk++; if ({res_valid, res_op, res_x, res_y} !== {1'b1, 2'b01, 8'h01, 8'h00})
      $display("FAIL mul_result got v%b op%b x%h y%h want v1 op01 x01 y00", res_valid, res_op, res_x, res_y); else n_pass++;
    tick(1'b0, 18'h0, 1'b1);
  endtask

  task automatic test_full_backpressure();
    logic [17:0] ins [6];
    logic [19:0] snap;
    for (int i = 0; i < 6; i++) ins[i] = 18'($urandom);
    for (int i = 0; i < 6; i++) tick(1'b1, ins[i], 1'b0);
    n_chk++; if (count !== 3'd4) $display("FAIL full_count got %0d want 4", count); else n_pass++;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got %b want 0", in_ready); else n_pass++;
    n_chk++; if ({res_valid, res_all} !== {1'b1, expect_res(ins[0])})
      $display("FAIL full_first_result got %b_%h want 1_%h", res_valid, res_all, expect_res(ins[0])); else n_pass++;
    snap = res_all;
    tick(1'b1, ins[5], 1'b0);
    tick(1'b1, ins[5], 1'b0);
    n_chk++; if ({res_valid, res_all, count} !== {1'b1, snap, 3'd4})
      $display("FAIL stall_hold got %b_%h_%0d want 1_%h_4", res_valid, res_all, count, snap); else n_pass++;
    for (int k = 1; k < 5; k++) begin
      tick(1'b0, 18'h0, 1'b1);
      n_chk++; if ({res_valid, res_all} !== {1'b1, expect_res(ins[k])})
        $display("FAIL drain_order_%0d got %b_%h want 1_%h", k, res_valid, res_all, expect_res(ins[k])); else n_pass++;
    end
    tick(1'b0, 18'h0, 1'b1);
    n_chk++; if ({res_valid, count} !== {1'b0, 3'd0})
      $display("FAIL drain_end got v%b cnt%0d want v0 cnt0", res_valid, count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int seen;
    for (int i = 0; i < 4; i++) tick(1'b1, 18'($urandom), 1'b0);
    n_chk++; if ({count, res_valid} !== {3'd3, 1'b1})
      $display("FAIL midrst_setup got cnt%0d v%b want cnt3 v1", count, res_valid); else n_pass++;
    do_reset();
    n_chk++; if ({count, res_valid, in_ready, res_all} !== {3'd0, 1'b0, 1'b1, 20'h0})
      $display("FAIL midrst_clear got cnt%0d v%b rdy%b res%h want cnt0 v0 rdy1 res0", count, res_valid, in_ready, res_all); else n_pass++;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 18'h0, 1'b1);
      if (res_valid !== 1'b0 || count !== 3'd0) seen++;
    end
    n_chk++; if (seen !== 0) $display("FAIL midrst_stale got %0d stale cycles want 0", seen); else n_pass++;
  endtask

  task automatic test_back_to_back_wrap();
    logic [17:0] a [13];
    do_reset();
    for (int i = 0; i < 13; i++) a[i] = 18'($urandom);
    tick(1'b1, a[0], 1'b0);
    tick(1'b1, a[1], 1'b0);
    tick(1'b1, a[2], 1'b0);
    n_chk++; if (count !== 3'd2) $display("FAIL b2b_setup got %0d want 2", count); else n_pass++;
    for (int j = 0; j < 10; j++) begin
      tick(1'b1, a[j + 3], 1'b1);
      n_chk++; if ({count, res_valid, res_all} !== {3'd2, 1'b1, expect_res(a[j + 1])})
        $display("FAIL b2b_%0d got cnt%0d v%b res%h want cnt2 v1 res%h", j, count, res_valid, res_all, expect_res(a[j + 1])); else n_pass++;
    end
    for (int i = 0; i < 4; i++) tick(1'b0, 18'h0, 1'b1);
  endtask

  task automatic test_random();
    logic v, rr;
    logic [17:0] ins;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      v   = ($urandom_range(0, 3) != 0);
      rr  = ($urandom_range(0, 3) != 0);
      ins = 18'($urandom);
      tick(v, ins, rr);
      n_chk++; if (count !== 3'(mq.size())) $display("FAIL rnd_count cyc%0d got %0d want %0d", c, count, mq.size()); else n_pass++;
      n_chk++; if (in_ready !== (mq.size() < DEPTH)) $display("FAIL rnd_in_ready cyc%0d got %b", c, in_ready); else n_pass++;
      n_chk++; if (res_valid !== m_vld) $display("FAIL rnd_res_valid cyc%0d got %b want %b", c, res_valid, m_vld); else n_pass++;
      n_chk++; if (alu_instr !== ((mq.size() > 0) ? mq[0] : 18'h0))
        $display("FAIL rnd_alu_instr cyc%0d got %h", c, alu_instr); else n_pass++;
      if (m_vld) begin
        n_chk++; if (res_all !== m_res) $display("FAIL rnd_result cyc%0d got %h want %h", c, res_all, m_res); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow();
    test_mul();
    test_full_backpressure();
    test_reset_mid();
    test_back_to_back_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
